// File: rtl/div_gen_if.sv
// Request/result bundle for div_gen: operands and mode in, quotient, remainder,
// handshake and status flags out.
interface div_gen_if #(
  parameter int unsigned DD_W = 8,
  parameter int unsigned DQ_W = 4
);
  logic            start;
  logic            mode;
  logic [DD_W-1:0] dd;
  logic [DQ_W-1:0] dq;
  logic [DD_W-1:0] ans;
  logic [DQ_W-1:0] are;
  logic            busy;
  logic            done;
  logic            dz;
  logic            ovf;

  modport master (
    output start, mode, dd, dq,
    input  ans, are, busy, done, dz, ovf
  );

  modport slave (
    input  start, mode, dd, dq,
    output ans, are, busy, done, dz, ovf
  );
endinterface

// File: rtl/div_gen.sv
// Sequential restoring divider, one quotient bit per clock, signed/unsigned with
// divide-by-zero and overflow flags and a busy/done handshake.
module div_gen #(
  parameter int unsigned DD_W = 8,
  parameter int unsigned DQ_W = 4
) (
  input logic      clock,
  input logic      reset,
  div_gen_if.slave bus
);
  localparam int unsigned CntW = $clog2(DD_W + 1);
  localparam logic [DD_W-1:0] DdMin = {1'b1, {(DD_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e          state_q;
  logic [DD_W-1:0] quo_q;
  logic [DQ_W-1:0] rem_q;
  logic [DQ_W-1:0] dvs_q;
  logic [CntW-1:0] cnt_q;
  logic            q_neg_q;
  logic            r_neg_q;
  logic            ovf_q;

  logic            dd_neg;
  logic            dq_neg;
  logic            ovf_in;
  logic [DD_W-1:0] dd_mag;
  logic [DQ_W-1:0] dq_mag;
  logic [DQ_W:0]   rem_sh;
  logic [DQ_W+1:0] trial;
  logic            q_bit;
  logic [DQ_W-1:0] rem_nxt;
  logic            unused_trial_bit;

  // Magnitudes read as unsigned, so the most-negative operand maps to 2^(W-1) exactly.
  always_comb begin
    dd_neg  = bus.mode & bus.dd[DD_W-1];
    dq_neg  = bus.mode & bus.dq[DQ_W-1];
    dd_mag  = dd_neg ? -bus.dd : bus.dd;
    dq_mag  = dq_neg ? -bus.dq : bus.dq;
    ovf_in  = bus.mode && (bus.dd == DdMin) && (bus.dq == '1);
    rem_sh  = {rem_q, quo_q[DD_W-1]};
    trial   = {1'b0, rem_sh} - {2'b00, dvs_q};
    q_bit   = ~trial[DQ_W+1];
    rem_nxt = q_bit ? trial[DQ_W-1:0] : rem_sh[DQ_W-1:0];
  end

  // A kept difference is always below the divisor, so this bit is zero whenever used.
  assign unused_trial_bit = trial[DQ_W];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      ovf_q    <= 1'b0;
      bus.ans  <= '0;
      bus.are  <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.dz   <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (bus.dq == '0) begin
              bus.ans  <= '1;
              bus.are  <= '0;
              bus.dz   <= 1'b1;
              bus.ovf  <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              quo_q    <= dd_mag;
              rem_q    <= '0;
              dvs_q    <= dq_mag;
              cnt_q    <= CntW'(DD_W);
              q_neg_q  <= dd_neg ^ dq_neg;
              r_neg_q  <= dd_neg;
              ovf_q    <= ovf_in;
              bus.busy <= 1'b1;
              state_q  <= StCalc;
            end
          end
        end
        StCalc: begin
          quo_q <= {quo_q[DD_W-2:0], q_bit};
          rem_q <= rem_nxt;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_q <= StFix;
        end
        StFix: begin
          // Overflow case needs no special result: |min| re-wraps to min unchanged.
          bus.ans  <= q_neg_q ? -quo_q : quo_q;
          bus.are  <= r_neg_q ? -rem_q : rem_q;
          bus.dz   <= 1'b0;
          bus.ovf  <= ovf_q;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule
